// File: rtl/calc_pkg.sv
// Shared key codes and sequencer state encoding for the keypad calculator.
package calc_pkg;

  localparam logic [3:0] KEY_COMMIT_A    = 4'hA;
  localparam logic [3:0] KEY_COMMIT_B    = 4'hB;
  localparam logic [3:0] KEY_NEXT_OP     = 4'hC;
  localparam logic [3:0] KEY_EXECUTE     = 4'hD;
  localparam logic [3:0] KEY_CLEAR_ENTRY = 4'hE;
  localparam logic [3:0] KEY_CLEAR_ALL   = 4'hF;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } calc_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

endpackage

// File: rtl/calc_entry.sv
// Hex digit entry: shifts digits in from the right until the register is full.
module calc_entry #(
  parameter int WIDTH = 16,
  localparam int DIGITS = WIDTH / 4,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             digit_i,
  input  logic [3:0]       digit_val_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] entry_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] entry_q, entry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      entry_d = '0;
      cnt_d   = '0;
    end else if (digit_i && (cnt_q < CNT_W'(DIGITS))) begin
      entry_d = {entry_q[WIDTH-5:0], digit_val_i};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign entry_o = entry_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: edits operands, issues one request to the
// arithmetic unit and captures its result, with a bounded wait.
//
// state | meaning
// EDIT  | accept keys, edit entry/operands/operation
// ISSUE | fu_start high, operands frozen until fu_ready
// WAIT  | request accepted, waiting for fu_done or timeout
// SHOW  | result just captured in reg_c, one cycle
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 1024,
  localparam int OP_W   = $clog2(NUM_OPS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_valid_i,
  input  logic [3:0]       key_value_i,
  input  logic             fu_ready_i,
  input  logic             fu_done_i,
  input  logic [WIDTH-1:0] fu_result_i,
  output logic             fu_start_o,
  output logic [WIDTH-1:0] fu_a_o,
  output logic [WIDTH-1:0] fu_b_o,
  output logic [OP_W-1:0]  fu_op_o,
  output logic [WIDTH-1:0] reg_a_o,
  output logic [WIDTH-1:0] reg_b_o,
  output logic [WIDTH-1:0] reg_c_o,
  output logic [WIDTH-1:0] entry_o,
  output logic [OP_W-1:0]  op_sel_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(WIDTH / 4 + 1);
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(NUM_OPS - 1);

  calc_state_t      state_q, state_d;
  logic [WIDTH-1:0] reg_a_q, reg_a_d;
  logic [WIDTH-1:0] reg_b_q, reg_b_d;
  logic [WIDTH-1:0] reg_c_q, reg_c_d;
  logic [OP_W-1:0]  op_sel_q, op_sel_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             fu_start_q, fu_start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             ent_digit;
  logic             ent_clear;
  logic [WIDTH-1:0] entry;
  logic [CNT_W-1:0] digit_cnt;

  calc_entry #(.WIDTH(WIDTH)) u_entry (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .digit_i     (ent_digit),
    .digit_val_i (key_value_i),
    .clear_i     (ent_clear),
    .entry_o     (entry),
    .cnt_o       (digit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    reg_c_d   = reg_c_q;
    op_sel_d  = op_sel_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    ent_digit = 1'b0;
    ent_clear = 1'b0;

    case (state_q)
      EDIT: begin
        if (key_valid_i) begin
          if (is_digit(key_value_i)) begin
            ent_digit = 1'b1;
          end else begin
            case (key_value_i)
              // Committing with no digits typed chains the previous result.
              KEY_COMMIT_A: begin
                reg_a_d   = (digit_cnt != '0) ? entry : reg_c_q;
                ent_clear = 1'b1;
              end
              KEY_COMMIT_B: begin
                reg_b_d   = (digit_cnt != '0) ? entry : reg_c_q;
                ent_clear = 1'b1;
              end
              KEY_NEXT_OP: begin
                op_sel_d = (op_sel_q == OP_LAST) ? '0 : op_sel_q + OP_W'(1);
              end
              KEY_EXECUTE:     state_d = ISSUE;
              KEY_CLEAR_ENTRY: ent_clear = 1'b1;
              KEY_CLEAR_ALL: begin
                ent_clear = 1'b1;
                reg_a_d   = '0;
                reg_b_d   = '0;
                reg_c_d   = '0;
                op_sel_d  = '0;
                err_d     = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      ISSUE: begin
        if (fu_ready_i) begin
          state_d = WAIT;
          tmr_d   = '0;
        end
      end
      WAIT: begin
        if (fu_done_i) begin
          reg_c_d = fu_result_i;
          state_d = SHOW;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = EDIT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SHOW:    state_d = EDIT;
      default: state_d = EDIT;
    endcase

    fu_start_d = (state_d == ISSUE);
    busy_d     = (state_d == ISSUE) || (state_d == WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EDIT;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      reg_c_q    <= '0;
      op_sel_q   <= '0;
      tmr_q      <= '0;
      fu_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_c_q    <= reg_c_d;
      op_sel_q   <= op_sel_d;
      tmr_q      <= tmr_d;
      fu_start_q <= fu_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign fu_start_o = fu_start_q;
  assign fu_a_o     = reg_a_q;
  assign fu_b_o     = reg_b_q;
  assign fu_op_o    = op_sel_q;
  assign reg_a_o    = reg_a_q;
  assign reg_b_o    = reg_b_q;
  assign reg_c_o    = reg_c_q;
  assign entry_o    = entry;
  assign op_sel_o   = op_sel_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with request/result scoreboard queues.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int T   = 16;
  localparam int OPW = 2;

  logic           clk_i       = 1'b0;
  logic           rst_ni      = 1'b1;
  logic           key_valid_i = 1'b0;
  logic [3:0]     key_value_i = 4'h0;
  logic           fu_ready_i  = 1'b0;
  logic           fu_done_i   = 1'b0;
  logic [W-1:0]   fu_result_i = '0;
  logic           fu_start_o;
  logic [W-1:0]   fu_a_o, fu_b_o, reg_a_o, reg_b_o, reg_c_o, entry_o;
  logic [OPW-1:0] fu_op_o, op_sel_o;
  logic           busy_o, err_o;

  calc_sequencer #(.WIDTH(W), .NUM_OPS(N), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .key_valid_i(key_valid_i), .key_value_i(key_value_i),
    .fu_ready_i(fu_ready_i), .fu_done_i(fu_done_i), .fu_result_i(fu_result_i),
    .fu_start_o(fu_start_o), .fu_a_o(fu_a_o), .fu_b_o(fu_b_o), .fu_op_o(fu_op_o),
    .reg_a_o(reg_a_o), .reg_b_o(reg_b_o), .reg_c_o(reg_c_o), .entry_o(entry_o),
    .op_sel_o(op_sel_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
  } req_t;

  req_t         exp_req[$];
  logic [W-1:0] exp_res[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk_i);
    key_valid_i = 1'b1;
    key_value_i = k;
    @(negedge clk_i);
    key_valid_i = 1'b0;
  endtask

  task automatic execute(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    exp_req.push_back(r);
    press(KEY_EXECUTE);
  endtask

  // Compares the pending request on every ISSUE cycle, pops on acceptance.
  task automatic watch_issue(input int i, inout int acc, inout int starts);
    if (fu_start_o) begin
      starts++;
      check("req_pending", 32'(exp_req.size() != 0), 1);
      if (exp_req.size() != 0) begin
        check("fu_a", fu_a_o, exp_req[0].a);
        check("fu_b", fu_b_o, exp_req[0].b);
        check("fu_op", fu_op_o, exp_req[0].op);
      end
      if (fu_ready_i && acc < 0) begin
        acc = i;
        if (exp_req.size() != 0) exp_req.delete(0);
      end
    end
  endtask

  task automatic run_req(input int rdy_dly, input int done_dly, input logic [W-1:0] res,
                         input bit poke, output int starts);
    int acc;
    acc    = -1;
    starts = 0;
    for (int i = 0; i < rdy_dly + done_dly + 3; i++) begin
      fu_ready_i = (i >= rdy_dly);
      watch_issue(i, acc, starts);
      fu_done_i   = (acc >= 0) && (i == acc + done_dly);
      key_valid_i = poke && (acc >= 0) && (i == acc + 1);
      key_value_i = 4'h5;
      if (fu_done_i) begin
        fu_result_i = res;
        exp_res.push_back(res);
        check("busy_wait", busy_o, 1);
      end
      @(negedge clk_i);
      key_valid_i = 1'b0;
      if (fu_done_i) begin
        fu_done_i = 1'b0;
        check("reg_c_show", reg_c_o, exp_res.pop_front());
        check("busy_show", busy_o, 0);
      end
    end
    fu_ready_i = 1'b0;
    check("req_accepted", 32'(acc >= 0), 1);
    check("result_drained", exp_res.size(), 0);
    check("busy_after_show", busy_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, acc, first_err;

    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_reg_a", reg_a_o, 0);
    check("rst_reg_b", reg_b_o, 0);
    check("rst_reg_c", reg_c_o, 0);
    check("rst_entry", entry_o, 0);
    check("rst_op_sel", op_sel_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fu_start", fu_start_o, 0);
    check("rst_err", err_o, 0);
    rst_ni = 1'b1;

    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("entry_1234", entry_o, 16'h1234);
    press(KEY_COMMIT_A);
    check("reg_a_1234", reg_a_o, 16'h1234);
    check("entry_clr_a", entry_o, 0);
    press(4'h5); press(KEY_COMMIT_B);
    check("reg_b_0005", reg_b_o, 16'h0005);
    check("entry_clr_b", entry_o, 0);

    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    check("entry_9876", entry_o, 16'h9876);
    press(4'h5);
    check("entry_full_hold", entry_o, 16'h9876);
    press(KEY_CLEAR_ALL);
    check("clr_all_a", reg_a_o, 0);
    check("clr_all_b", reg_b_o, 0);
    check("clr_all_c", reg_c_o, 0);
    check("clr_all_entry", entry_o, 0);
    check("clr_all_op", op_sel_o, 0);

    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(KEY_CLEAR_ENTRY);
    check("clr_entry", entry_o, 0);
    press(4'h5);
    check("entry_after_clr", entry_o, 16'h0005);
    press(KEY_CLEAR_ENTRY);

    press(4'h3); press(KEY_COMMIT_A); press(4'h4); press(KEY_COMMIT_B);
    check("reg_a_3", reg_a_o, 16'h0003);
    check("reg_b_4", reg_b_o, 16'h0004);
    execute(16'h0003, 16'h0004, 2'd0);
    check("busy_issue", busy_o, 1);
    run_req(5, 3, 16'h0007, 1'b0, starts);
    check("fu_start_cycles", starts, 6);
    check("reg_c_7", reg_c_o, 16'h0007);

    press(KEY_COMMIT_A);
    check("reg_a_chain", reg_a_o, 16'h0007);
    press(4'h2); press(KEY_COMMIT_B);
    check("reg_b_2", reg_b_o, 16'h0002);
    execute(16'h0007, 16'h0002, 2'd0);
    run_req(0, 2, 16'h0009, 1'b1, starts);
    check("fu_start_cycles_2", starts, 1);
    check("entry_key_in_wait", entry_o, 0);
    check("reg_c_9", reg_c_o, 16'h0009);

    execute(16'h0007, 16'h0002, 2'd0);
    acc = -1; first_err = -1; starts = 0;
    for (int i = 0; i < 40; i++) begin
      fu_ready_i = 1'b1;
      watch_issue(i, acc, starts);
      if (err_o && first_err < 0) first_err = i;
      @(negedge clk_i);
    end
    fu_ready_i = 1'b0;
    check("timeout_accepted", acc, 0);
    check("timeout_err_cycle", first_err - acc, T + 1);
    check("timeout_err", err_o, 1);
    check("timeout_busy", busy_o, 0);
    check("timeout_fu_start", fu_start_o, 0);
    check("timeout_reg_c", reg_c_o, 16'h0009);
    @(negedge clk_i);
    fu_done_i = 1'b1; fu_result_i = 16'hFFFF;
    @(negedge clk_i);
    fu_done_i = 1'b0;
    @(negedge clk_i);
    check("stray_done_reg_c", reg_c_o, 16'h0009);
    check("stray_done_err", err_o, 1);
    check("stray_done_busy", busy_o, 0);
    press(4'h1);
    check("edit_after_timeout", entry_o, 16'h0001);
    press(KEY_CLEAR_ALL);
    check("err_cleared", err_o, 0);

    press(4'h6); press(KEY_COMMIT_A);
    check("reg_a_6", reg_a_o, 16'h0006);
    for (int k = 1; k <= 5; k++) begin
      press(KEY_NEXT_OP);
      check("op_sel_step", op_sel_o, k % N);
    end

    execute(16'h0006, 16'h0000, 2'd1);
    acc = -1; starts = 0;
    fu_ready_i = 1'b1;
    watch_issue(0, acc, starts);
    @(negedge clk_i);
    fu_ready_i = 1'b0;
    check("rstw_accepted", acc, 0);
    check("rstw_busy", busy_o, 1);
    check("rstw_fu_start", fu_start_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reg_a", reg_a_o, 0);
    check("async_reg_b", reg_b_o, 0);
    check("async_reg_c", reg_c_o, 0);
    check("async_entry", entry_o, 0);
    check("async_op_sel", op_sel_o, 0);
    check("async_fu_op", fu_op_o, 0);
    check("async_busy", busy_o, 0);
    check("async_fu_start", fu_start_o, 0);
    check("async_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    fu_done_i = 1'b1; fu_result_i = 16'h1111;
    @(negedge clk_i);
    fu_done_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_done_reg_c", reg_c_o, 0);
    check("post_rst_busy", busy_o, 0);
    check("req_queue_empty", exp_req.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits, a multiple of 4 in the range 8..32.
REQ-002 The block SHALL have parameter NUM_OPS, default 4: number of selectable operations, at least 2; OP_W = $clog2(NUM_OPS).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024: maximum number of cycles to wait for fu_done.
REQ-004 clk  in  1  single system clock; all state is clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 key_valid  in  1  one-cycle strobe from the keypad decoder.
REQ-007 key_value  in  4  key code, valid when key_valid=1.
REQ-008 fu_ready  in  1  the arithmetic unit can accept a request.
REQ-009 fu_done  in  1  one-cycle strobe: fu_result is valid.
REQ-010 fu_result  in  WIDTH  result from the arithmetic unit.
REQ-011 fu_start  out  1  request to the arithmetic unit.
REQ-012 fu_a, fu_b  out  WIDTH each  equal to reg_a and reg_b.
REQ-013 fu_op  out  OP_W  equal to op_sel.
REQ-014 reg_a, reg_b, reg_c  out  WIDTH each  operands and result, for the display.
REQ-015 entry  out  WIDTH  digit entry currently in progress.
REQ-016 op_sel  out  OP_W  currently selected operation.
REQ-017 busy  out  1  high in ISSUE and WAIT.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 Key codes SHALL be: 0x0-0x9 digit; 0xA commit to A; 0xB commit to B; 0xC next operation; 0xD execute; 0xE clear entry; 0xF clear all.
REQ-020 A digit key SHALL shift entry left by 4 and insert key_value in bits [3:0], then increment digit_cnt.
REQ-021 Once digit_cnt = WIDTH/4, further digit keys SHALL be ignored: entry and digit_cnt hold.
REQ-022 0xA SHALL load reg_a with entry when digit_cnt>0, or with reg_c (chaining) when digit_cnt=0; in both cases entry and digit_cnt clear. 0xB behaves identically for reg_b.
REQ-023 0xC SHALL increment op_sel modulo NUM_OPS (NUM_OPS-1 wraps to 0).
REQ-024 0xE SHALL clear entry and digit_cnt; 0xF SHALL clear entry, digit_cnt, reg_a, reg_b, reg_c, op_sel and err.
REQ-025 The FSM SHALL have four states: EDIT, ISSUE, WAIT and SHOW.
REQ-026 EDIT: keys are processed per REQ-019..024; 0xD moves to ISSUE on the next cycle.
REQ-027 ISSUE: fu_start=1; fu_a, fu_b and fu_op SHALL be held stable; in a cycle with fu_ready=1 the request is accepted and the FSM goes to WAIT (fu_start returns to 0 in WAIT).
REQ-028 WAIT: on fu_done, reg_c SHALL load fu_result and the FSM goes to SHOW. fu_done in the same cycle as acceptance is not sampled.
REQ-029 WAIT: a cycle counter starts at 0 on entry; when it reaches TIMEOUT-1 with no fu_done, the FSM SHALL set err=1, leave reg_c unchanged and go to EDIT.
REQ-030 SHOW SHALL last one cycle and then return to EDIT.
REQ-031 Key strobes SHALL be ignored (dropped, not queued) in ISSUE, WAIT and SHOW.
REQ-032 fu_done outside WAIT SHALL be ignored.
REQ-033 err SHALL clear only on reset or key 0xF.
REQ-034 All outputs SHALL be registered, except fu_a, fu_b and fu_op, which are direct copies of registers.

Reset
REQ-035 reset low SHALL asynchronously force: state=EDIT; entry, digit_cnt, reg_a, reg_b, reg_c, op_sel, the timeout counter, fu_start, busy and err all 0.
REQ-036 Reset asserted mid-ISSUE or mid-WAIT SHALL abandon the request; a later fu_done is ignored per REQ-032.

Structure
REQ-037 Shared package calc_pkg SHALL hold the key-code constants (KEY_COMMIT_A .. KEY_CLEAR_ALL) and the enum calc_state_t {EDIT, ISSUE, WAIT, SHOW}.
REQ-038 The digit shift register and digit counter SHALL be a sub-module calc_entry (parameter WIDTH; inputs: digit strobe, digit value, clear); everything else lives in calc_sequencer.

Verification
REQ-039 Keys 1,2,3,4,A,5,B with WIDTH=16 -> reg_a=0x1234, reg_b=0x0005, entry=0.
REQ-040 Keys 9,8,7,6,5 -> entry=0x9876 (fifth digit dropped); then 0xF -> all registers 0.
REQ-041 reg_a=0x0003, reg_b=0x0004, key D, fu_ready held low for 5 cycles then high, fu_done 3 cycles later with fu_result=0x0007 -> fu_start high for exactly 6 cycles, reg_c=0x0007, busy low one cycle after SHOW.
REQ-042 With TIMEOUT=16, key D and fu_done never asserted -> err=1 exactly 16 cycles after entry into WAIT, state=EDIT, reg_c unchanged; a later stray fu_done changes nothing.
REQ-043 After reg_c=0x0007, keys A then 2,B,D -> reg_a=0x0007 (chain), reg_b=0x0002, request issued; digit keys pressed during WAIT do not change entry.
REQ-044 Key C pressed 5 times with NUM_OPS=4 -> op_sel=1; reset asserted during WAIT -> all outputs 0 immediately (asynchronously).
